// File: rtl/ll_scoreboard.sv
// Long-latency writeback scoreboard: tracks in-flight load/div destinations and stalls ID on a RAW hazard.
// Optional consistency checker (sticky err output) is enabled by defining SCOREBOARD_CHECK_EN.
module ll_scoreboard #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic [4:0]       ID_rd,
  input  logic [2:0]       ID_ValidReg,
  input  logic             ID_LongLat,
  input  logic             ID_issue,
  input  logic             EX_flush,
  input  logic             WB_ll_done,
  input  logic [4:0]       WB_rd,
  output logic             stall,
  output logic [31:0]      pending,
  output logic [PTR_W:0]   count
`ifdef SCOREBOARD_CHECK_EN
  ,
  output logic             err
`endif
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [4:0]       tag_reg [DEPTH];
  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   count_reg, count_next;
  logic             ex_ll_reg;

  logic [DEPTH-1:0] entry_valid;
  logic [DEPTH-1:0] entry_hit;
  logic [31:0]      entry_dec [DEPTH];

  logic rs1_rd, rs2_rd;
  logic hit, full_blk;
  logic push, pop, squash;

  // x0 reads never depend on anything in flight
  assign rs1_rd = ID_ValidReg[1] & (ID_rs1 != 5'd0);
  assign rs2_rd = ID_ValidReg[2] & (ID_rs2 != 5'd0);

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      logic             is_retiring;
      logic             src_match;

      assign age         = PTR_W'(gi) - head_reg;
      assign entry_valid[gi] = ({1'b0, age} < count_reg);
      // The retiring head is visible to ID through the write-first register file
      assign is_retiring = WB_ll_done & (age == '0);
      assign src_match   = (rs1_rd & (tag_reg[gi] == ID_rs1)) |
                           (rs2_rd & (tag_reg[gi] == ID_rs2));
      assign entry_hit[gi] = entry_valid[gi] & ~is_retiring & src_match;
      assign entry_dec[gi] = entry_valid[gi] ? (32'd1 << tag_reg[gi]) : 32'd0;
    end
  endgenerate

  assign hit      = |entry_hit;
  assign full_blk = ID_LongLat & ID_ValidReg[0] & (count_reg == DEPTH_C) & ~WB_ll_done;
  assign stall    = hit | full_blk;

  assign push = ID_issue & ~stall & ID_LongLat & ID_ValidReg[0] & (ID_rd != 5'd0);
  assign pop  = WB_ll_done & (count_reg != '0);
  // A squash can only remove an entry that is not also leaving through WB this cycle
  assign squash = EX_flush & ex_ll_reg & (count_reg > (PTR_W+1)'(pop));

  // A push that coincides with a squash reuses the squashed tail slot
  assign wr_ptr = squash ? (tail_reg - PTR_W'(1)) : tail_reg;

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pending = pending | entry_dec[i];
    end
    pending[0] = 1'b0;
  end

  always_comb begin
    head_next = pop ? (head_reg + PTR_W'(1)) : head_reg;
    case ({push, squash})
      2'b10:   tail_next = tail_reg + PTR_W'(1);
      2'b01:   tail_next = tail_reg - PTR_W'(1);
      default: tail_next = tail_reg;
    endcase
    count_next = count_reg + (PTR_W+1)'(push) - (PTR_W+1)'(pop) - (PTR_W+1)'(squash);
  end

  assign count = count_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
      ex_ll_reg <= 1'b0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
      ex_ll_reg <= push;
    end
  end

  // Tag storage carries no reset; validity comes solely from head/count
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      tag_reg[wr_ptr] <= ID_rd;
    end
  end

`ifdef SCOREBOARD_CHECK_EN
  logic err_reg;

  assign err = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      if (WB_ll_done && (count_reg == '0)) begin
        err_reg <= 1'b1;
        $display("ll_scoreboard: completion with empty scoreboard (WB_rd=%0d)", WB_rd);
      end
      if (pop && (WB_rd != tag_reg[head_reg])) begin
        err_reg <= 1'b1;
        $display("ll_scoreboard: out-of-order completion WB_rd=%0d head=%0d", WB_rd, tag_reg[head_reg]);
      end
      if (push && (count_reg == DEPTH_C) && !pop) begin
        err_reg <= 1'b1;
        $display("ll_scoreboard: push into full scoreboard (rd=%0d)", ID_rd);
      end
    end
  end
`endif

endmodule

// File: doc/ll_scoreboard.md
Name: ll_scoreboard

Overview:
- Producer-side hazard tracker for long-latency writebacks: loads, and the multi-cycle divider when present.
- Records the rd of every long-latency instruction leaving ID and holds it until that result reaches WB.
- Stalls ID while an instruction reads a register that still has a result in flight.
- Complements the EX-stage forwarding path, which only covers results already available in MEM/WB.
- Sits beside the decode stage; stall drives the PC/IF/ID enables and a bubble into EX.

Parameters:
- DEPTH, 4, maximum outstanding long-latency ops; power of two, at least 2.
- PTR_W, 2, log2(DEPTH).

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- ID_rs1  in  5  source register 1 of the instruction in ID
- ID_rs2  in  5  source register 2 of the instruction in ID
- ID_rd  in  5  destination register of the instruction in ID
- ID_ValidReg  in  3  bit0 = rd written, bit1 = rs1 read, bit2 = rs2 read
- ID_LongLat  in  1  ID instruction is long-latency (load/div)
- ID_issue  in  1  pipeline wants to advance ID into EX this cycle
- EX_flush  in  1  instruction currently in EX is squashed
- WB_ll_done  in  1  oldest long-latency result is written in WB this cycle
- WB_rd  in  5  rd being written in WB
- stall  out  1  hold IF/ID and inject a bubble into EX
- pending  out  32  bitmap of registers with an in-flight long-latency result; bit0 always 0
- count  out  PTR_W+1  number of valid entries

Behaviour:
- Storage: in-order circular FIFO of DEPTH rd tags (head = oldest), plus an ex_ll flag that marks the tail entry as belonging to the instruction now in EX.
- Reset (synchronous, rst=1): head=tail=0, count=0, ex_ll=0, stall=0, pending=0. Reset overrides every same-cycle input.
- hit: some valid entry, excluding the head when WB_ll_done=1, equals an ID source with its ValidReg bit set.
  - Sources equal to x0 never hit.
  - The head is excluded because the register file is write-first, so ID reads the WB value in the same cycle.
- full_blk = ID_LongLat & ID_ValidReg[0] & (count==DEPTH) & ~WB_ll_done.
- stall = hit | full_blk, combinational from current inputs and state.
- push = ID_issue & ~stall & ID_LongLat & ID_ValidReg[0] & (ID_rd!=0); writes ID_rd at tail, tail+1.
- pop = WB_ll_done & (count!=0); head+1.
- Squash: EX_flush & ex_ll removes the tail entry (tail-1).
- ex_ll next value = push; it is cleared by any non-push cycle, including stall bubbles.
- Simultaneous events, all applied in one cycle:
  - Squash and push together: the new entry overwrites the squashed tail slot; tail and count unchanged by the pair.
  - Pop and push on a full FIFO: allowed; count unchanged.
  - Pop and squash with count==1: FIFO empties; head=tail after update.
- count_next = count + push - pop - squash; it never exceeds DEPTH and never underflows.
- Pointers wrap modulo DEPTH.
- pending is recomputed each cycle as the OR-decode of all valid entries. Duplicate rd entries are legal; the bit stays set until the last one pops.
- WB_ll_done with count==0 is ignored; state unchanged.
- Latency: an entry pushed in cycle N makes pending and hit visible in cycle N+1. A pop in cycle N releases stall in the same cycle N.

Optional Feature:
- Macro: SCOREBOARD_CHECK_EN.
- When defined:
  - Adds output err (1 bit, sticky until rst, reset 0).
  - err sets on WB_ll_done with count==0 (underflow).
  - err sets on WB_ll_done where WB_rd != head tag (out-of-order completion).
  - err sets on push while count==DEPTH and no pop.
  - Simulation emits a $display with the cause.
- When undefined: no err port, no extra logic; behaviour otherwise identical.

Test Plan:
- Load-use: cycle 0 issue load rd=5 (LongLat=1, ValidReg=001). Cycle 1 ID reads rs1=5 (ValidReg=011) -> stall=1, pending[5]=1. Held until WB_ll_done with WB_rd=5 -> stall=0 that cycle; pending[5]=0 next cycle.
- x0 destination: issue load rd=0 -> no push, count=0. A following reader of x0 -> stall=0.
- Full FIFO: push rd=1,2,3,4, then a fifth load in ID -> stall=1, count=4. Assert WB_ll_done (head=1) -> stall=0, fifth push accepted, count stays 4.
- Squash: push rd=7, next cycle EX_flush=1 -> count returns to 0, pending[7]=0. Same test with a simultaneous new push rd=9 -> count=1, pending = only bit 9.
- Reset mid-operation: three entries valid, stall=1, rst=1 for one cycle -> count=0, pending=0, stall=0 next cycle; a WB_ll_done arriving with rst ignored.
- With SCOREBOARD_CHECK_EN: WB_ll_done on empty -> err=1 and stays 1 until rst. Head rd=3 but WB_rd=4 -> err=1.
